valid_code_gen: RTL and testbench

VALID_CODE_GEN -- requirements
Module: valid_code_gen

---
 rtl/valid_code_gen.sv | 113 +++++++++++
 tb/tb_valid_code_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/valid_code_gen.sv
// rtl/valid_code_gen.sv - scans all 64 six-bit candidates per lap and emits those that satisfy the validity predicate.
// Optional GEN_COUNT_EN adds output num_emitted[6:0], the number of codes handed off in the current or last lap.
module valid_code_gen #(
  parameter logic [5:0] SEED = 6'd0
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       start,
  output logic [5:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       done,
  output logic       wrapped
`ifdef GEN_COUNT_EN
  ,
  output logic [6:0] num_emitted
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, PRESENT, DONE} state_t;

  state_t     state, state_n;
  logic [5:0] cand, cand_n, code_n;
  logic [6:0] cnt, cnt_n;
  logic       valid_n, wrapped_n;
  logic       a, b, c, d, e, f, v;

  assign {a, b, c, d, e, f} = cand;
  assign v = (!a & !b & !c & !d & !e & f) | (!a & !b & c & e & f) | (!a & b & !c & e & f) |
             (!a & b & d & !f) | (!a & b & c & !d) | (a & !b & c & f) |
             (b & !e & !f) | (c & !d & !e) | (a & !f);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    code_n    = code_out;
    valid_n   = code_valid;
    wrapped_n = wrapped;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = SEARCH;
          cand_n    = SEED;
          cnt_n     = 7'd0;
          wrapped_n = 1'b0;
        end
      end
      SEARCH: begin
        cnt_n = cnt + 7'd1;
        if (v) begin
          code_n  = cand;
          valid_n = 1'b1;
          state_n = PRESENT;
        end else begin
          cand_n = cand + 6'd1;
          if (&cand) wrapped_n = 1'b1;
          // The 64th rejected candidate closes the lap without a wasted cycle.
          if (cnt == 7'd63) state_n = DONE;
        end
      end
      PRESENT: begin
        if (code_ready) begin
          valid_n = 1'b0;
          if (cnt == 7'd64) begin
            state_n = DONE;
          end else begin
            state_n = SEARCH;
            cand_n  = cand + 6'd1;
            if (&cand) wrapped_n = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state      <= IDLE;
      cand       <= SEED;
      cnt        <= 7'd0;
      code_out   <= 6'd0;
      code_valid <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      cnt        <= cnt_n;
      code_out   <= code_n;
      code_valid <= valid_n;
      wrapped    <= wrapped_n;
    end
  end

`ifdef GEN_COUNT_EN
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      num_emitted <= 7'd0;
    end else if (state == IDLE && start) begin
      num_emitted <= 7'd0;
    end else if (state == PRESENT && code_ready) begin
      num_emitted <= num_emitted + 7'd1;
    end
  end
`endif

endmodule

// File: tb/tb_valid_code_gen.sv
// tb/tb_valid_code_gen.sv - directed bench for valid_code_gen with a code scoreboard; SEED=0 and SEED=63 instances.
module tb_valid_code_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst0, start0, ready0, valid0, busy0, done0, wrap0;
  logic       rst1, start1, ready1, valid1, busy1, done1, wrap1;
  logic [5:0] code0, code1;
`ifdef GEN_COUNT_EN
  logic [6:0] nem0, nem1;
`endif

  valid_code_gen #(.SEED(6'd0)) dut0 (
    .clock(clock), .reset_N(rst0), .start(start0), .code_out(code0), .code_valid(valid0),
    .code_ready(ready0), .busy(busy0), .done(done0), .wrapped(wrap0)
`ifdef GEN_COUNT_EN
    , .num_emitted(nem0)
`endif
  );

  valid_code_gen #(.SEED(6'd63)) dut1 (
    .clock(clock), .reset_N(rst1), .start(start1), .code_out(code1), .code_valid(valid1),
    .code_ready(ready1), .busy(busy1), .done(done1), .wrapped(wrap1)
`ifdef GEN_COUNT_EN
    , .num_emitted(nem1)
`endif
  );

  int         n_assert = 0;
  int         n_fail = 0;
  int         hs0 = 0, hs1 = 0, done_cnt0 = 0, starts0 = 0;
  logic       busy0_d = 1'b0;
  logic [5:0] q0[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit vmodel(input logic [5:0] x);
    bit a, b, c, d, e, f;
    {a, b, c, d, e, f} = x;
    return (!a && !b && !c && !d && !e && f) || (!a && !b && c && e && f) ||
           (!a && b && !c && e && f) || (!a && b && d && !f) || (!a && b && c && !d) ||
           (a && !b && c && f) || (b && !e && !f) || (c && !d && !e) || (a && !f);
  endfunction

  task automatic push_lap(input logic [5:0] seed, output int n);
    logic [5:0] x;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      x = seed + 6'(i);
      if (vmodel(x)) begin
        q0.push_back(x);
        n++;
      end
    end
  endtask

  // Scoreboard pops one expected code per handshake on dut0.
  always @(negedge clock) begin
    if (valid0 && ready0) begin
      hs0++;
      if (q0.size() == 0) check("sb0_underflow", 32'd1, 32'd0);
      else check("sb0_code", 32'(code0), 32'(q0.pop_front()));
    end
    if (done0) done_cnt0++;
    if (busy0 && !busy0_d) starts0++;
    busy0_d = busy0;
    if (valid1 && ready1) hs1++;
  end

  initial begin
    int n0, t, seen, s_snap, d_snap, h_snap;
    rst0 = 0; rst1 = 0; start0 = 0; start1 = 0; ready0 = 0; ready1 = 0;
    repeat (3) @(posedge clock);
    #1 rst0 = 1; rst1 = 1;
    @(negedge clock);
    check("rst_valid0", valid0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_wrap0", wrap0, 0);
    check("rst_code0", code0, 0);
    check("rst_valid1", valid1, 0);
`ifdef GEN_COUNT_EN
    check("rst_nem0", nem0, 0);
`endif
    repeat (4) @(negedge clock);
    check("idle_hold_code0", code0, 0);
    check("idle_hold_busy0", busy0, 0);
    check("idle_hold_busy1", busy1, 0);

    // SEED=0 lap with code_ready high: latency and full emitted set.
    ready0 = 1;
    push_lap(6'd0, n0);
    h_snap = hs0;
    @(posedge clock); #1 start0 = 1;
    @(posedge clock); #1 start0 = 0;
    @(negedge clock);
    check("lat_e0_busy", busy0, 1);
    check("lat_e0_valid", valid0, 0);
    @(negedge clock);
    check("lat_e1_valid", valid0, 0);
    @(negedge clock);
    check("lat_e2_valid", valid0, 1);
    check("lat_e2_code", code0, 6'b000001);
    t = 0;
    while (!done0 && t < 400) begin @(negedge clock); t++; end
    check("lap0_done_seen", done0, 1);
    @(negedge clock);
    check("lap0_busy_fall", busy0, 0);
    check("lap0_done_once", done_cnt0, 1);
    check("lap0_handshakes", hs0 - h_snap, n0);
    check("lap0_sb_empty", q0.size(), 0);
`ifdef GEN_COUNT_EN
    check("lap0_num_emitted", nem0, n0);
`endif

    // SEED=63 with backpressure: 63 and 0 rejected, 1 presented and held.
    ready1 = 0;
    @(posedge clock); #1 start1 = 1;
    @(posedge clock); #1 start1 = 0;
    t = 0;
    while (!valid1 && t < 100) begin @(negedge clock); t++; end
    check("s63_first_code", code1, 6'b000001);
    check("s63_wrapped", wrap1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_code_stable", code1, 6'b000001);
      check("bp_valid_stable", valid1, 1);
    end
    @(posedge clock); #1 ready1 = 1;
    @(posedge clock); #1 ready1 = 0;
    @(negedge clock);
    check("bp_valid_drop", valid1, 0);
    t = 0;
    while (!valid1 && t < 100) begin @(negedge clock); t++; end
    check("bp_next_code", code1, 6'b001000);
    check("bp_one_transfer", hs1, 1);

    // Reset while presenting, then a fresh lap restarts from SEED.
    @(posedge clock); #2 rst1 = 0;
    #1;
    check("mid_rst_valid", valid1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_code", code1, 0);
    check("mid_rst_wrap", wrap1, 0);
    @(posedge clock); #1 rst1 = 1;
    repeat (3) @(negedge clock);
    check("post_rst_valid", valid1, 0);
    check("post_rst_busy", busy1, 0);
    ready1 = 1;
    @(posedge clock); #1 start1 = 1;
    @(posedge clock); #1 start1 = 0;
    t = 0;
    while (!valid1 && t < 100) begin @(negedge clock); t++; end
    check("restart_code", code1, 6'b000001);
    t = 0;
    while (!done1 && t < 400) begin @(negedge clock); t++; end
    check("lap1_done_seen", done1, 1);

    // start held high: exactly one new lap per IDLE sample.
    push_lap(6'd0, n0);
    push_lap(6'd0, n0);
    s_snap = starts0;
    d_snap = done_cnt0;
    @(posedge clock); #1 start0 = 1;
    seen = 0;
    t = 0;
    while (seen < 2 && t < 1000) begin
      @(negedge clock);
      t++;
      if (done0) begin
        seen++;
        if (seen == 2) begin
          start0 = 0;
        end else begin
          @(negedge clock);
          check("held_gap_idle", busy0, 0);
          @(negedge clock);
          check("held_restart", busy0, 1);
        end
      end
    end
    check("held_two_dones", seen, 2);
    repeat (3) @(negedge clock);
    check("held_busy_low", busy0, 0);
    check("held_starts", starts0 - s_snap, 2);
    check("held_done_pulses", done_cnt0 - d_snap, 2);
    check("held_sb_empty", q0.size(), 0);
`ifdef GEN_COUNT_EN
    check("held_num_emitted", nem0, n0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
